// File: rtl/led_bank_mux.sv
// Multi-bank LED shift-out engine: serialises BANKS*LANES frames onto a shared
// data bus with a common data clock and one latch strobe per bank.
module led_bank_mux #(
  parameter int FRAME_LENGTH = 32,
  parameter int LANES        = 9,
  parameter int BANKS        = 2,
  parameter int PHASE_CYCLES = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                go,
  input  logic [BANKS*LANES*FRAME_LENGTH-1:0] frames,
  output logic                                dclk,
  output logic [BANKS-1:0]                    latch,
  output logic [LANES-1:0]                    data,
  output logic                                idle,
  output logic                                done
);
  localparam int FW  = BANKS*LANES*FRAME_LENGTH;
  localparam int BKW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int BNW = $clog2(FRAME_LENGTH+1);
  localparam int PHW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

  localparam logic [BKW-1:0] BK_LAST   = BKW'(BANKS-1);
  localparam logic [PHW-1:0] PH_LAST   = PHW'(PHASE_CYCLES-1);
  localparam logic [BNW-1:0] BIT_FIRST = MSB_FIRST ? BNW'(FRAME_LENGTH-1) : BNW'(0);
  localparam logic [BNW-1:0] BIT_LAST  = MSB_FIRST ? BNW'(0) : BNW'(FRAME_LENGTH-1);

  typedef enum logic [2:0] {IDLE, SETUP, LATCH, CLOCK, DROP} state_t;

  state_t          state, state_nx;
  logic [BKW-1:0]  bank, bank_nx;
  logic [BNW-1:0]  bitn, bitn_nx;
  logic [PHW-1:0]  ph, ph_nx;
  logic [FW-1:0]   shadow, src;
  logic            load, adv;
  logic            dclk_nx, done_nx;
  logic [BANKS-1:0] latch_nx;
  logic [LANES-1:0] data_nx;

  assign idle = (state == IDLE);

  always_comb begin
    state_nx = state;
    bank_nx  = bank;
    bitn_nx  = bitn;
    ph_nx    = ph;
    src      = shadow;
    load     = 1'b0;
    dclk_nx  = dclk;
    latch_nx = latch;
    data_nx  = data;
    done_nx  = 1'b0;
    adv      = (ph == PH_LAST);

    if (state != IDLE) ph_nx = adv ? PHW'(0) : ph + PHW'(1);

    case (state)
      IDLE: if (go) begin
        state_nx = SETUP;
        load     = 1'b1;
        src      = frames;
        bank_nx  = '0;
        bitn_nx  = BIT_FIRST;
        ph_nx    = '0;
      end
      SETUP: if (adv) state_nx = LATCH;
      LATCH: if (adv) state_nx = CLOCK;
      CLOCK: if (adv) state_nx = DROP;
      DROP: if (adv) begin
        if (bank != BK_LAST) begin
          bank_nx  = bank + BKW'(1);
          state_nx = SETUP;
        end else if (bitn != BIT_LAST) begin
          bank_nx  = '0;
          bitn_nx  = MSB_FIRST ? bitn - BNW'(1) : bitn + BNW'(1);
          state_nx = SETUP;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Every transition changes state, so entry actions key off state_nx.
    if (state_nx != state) begin
      case (state_nx)
        SETUP: begin
          dclk_nx = 1'b0;
          for (int l = 0; l < LANES; l++)
            data_nx[LANES-1-l] = src[(int'(bank_nx)*LANES + l)*FRAME_LENGTH + int'(bitn_nx)];
        end
        LATCH: latch_nx[bank] = 1'b1;
        CLOCK: dclk_nx = 1'b1;
        DROP:  latch_nx = '0;
        IDLE: begin
          data_nx  = '0;
          dclk_nx  = 1'b1;
          latch_nx = '0;
          done_nx  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bank  <= '0;
      bitn  <= '0;
      ph    <= '0;
      dclk  <= 1'b1;
      latch <= '0;
      data  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      bank  <= bank_nx;
      bitn  <= bitn_nx;
      ph    <= ph_nx;
      dclk  <= dclk_nx;
      latch <= latch_nx;
      data  <= data_nx;
      done  <= done_nx;
    end
  end

  // Snapshot needs no reset; its contents only matter after a start.
  always_ff @(posedge clk) begin
    if (load) shadow <= frames;
  end
endmodule

// File: tb/tb_led_bank_mux.sv
// Bench for led_bank_mux: default-parameter instance checked against a
// closed-form cycle model, plus a small instance checked from a vector table.
module tb_led_bank_mux;
  localparam int FL = 32, L = 9, B = 2, PC = 1;
  localparam int N  = 4*PC*B*FL;
  localparam int FW = B*L*FL;

  logic          clk, reset, go, go_m;
  logic [FW-1:0] frames;
  logic [23:0]   frames_m;
  logic          dclk, idle, done, dclk_m, idle_m, done_m;
  logic [1:0]    latch;
  logic [8:0]    data;
  logic [2:0]    latch_m;
  logic [1:0]    data_m;
  int            checks = 0, errors = 0;
  logic          rst_q;

  led_bank_mux u_dut (
    .clk(clk), .reset(reset), .go(go), .frames(frames),
    .dclk(dclk), .latch(latch), .data(data), .idle(idle), .done(done));

  led_bank_mux #(.FRAME_LENGTH(4), .LANES(2), .BANKS(3), .PHASE_CYCLES(2), .MSB_FIRST(1'b0)) u_map (
    .clk(clk), .reset(reset), .go(go_m), .frames(frames_m),
    .dclk(dclk_m), .latch(latch_m), .data(data_m), .idle(idle_m), .done(done_m));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected {data,dclk,latch,idle,done} c cycles after the go-sampling edge.
  function automatic logic [13:0] exp_d(input logic [FW-1:0] f, input int c);
    logic [8:0] d;
    int s, step, p, bk, bi, n;
    if (c == N) return {9'h0, 1'b1, 2'b00, 1'b1, 1'b1};
    if (c > N)  return {9'h0, 1'b1, 2'b00, 1'b1, 1'b0};
    s = c / PC; step = s / 4; p = s % 4;
    bk = step % B; bi = step / B; n = FL-1-bi;
    for (int l = 0; l < L; l++) d[L-1-l] = f[(bk*L+l)*FL + n];
    return {d, (p >= 2), ((p == 1 || p == 2) ? 2'(1 << bk) : 2'b00), 1'b0, 1'b0};
  endfunction

  function automatic logic [FW-1:0] rand_frames();
    logic [FW-1:0] f;
    for (int i = 0; i < FW/32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic xfer(input logic [FW-1:0] f, input bit keep, input bit poke, input bit chg);
    logic pd;
    int rises, dn, busy;
    rises = 0; dn = 0; busy = 0; pd = 1'b1;
    frames = f; go = 1'b1;
    for (int c = 0; c <= N; c++) begin
      @(negedge clk);
      chk($sformatf("xfer_c%0d", c), {data, dclk, latch, idle, done}, exp_d(f, c));
      if (dclk && !pd) rises++;
      pd = dclk;
      if (done) dn++;
      if (!idle) busy++;
      if (!keep) begin
        if (c == 0) go = 1'b0;
        if (poke && c == 100) go = 1'b1;
        if (poke && c == 101) go = 1'b0;
      end
      if (chg && c == 0) frames = '1;
    end
    chk("dclk_rises", rises, B*FL);
    chk("done_pulses", dn, 1);
    chk("busy_cycles", busy, N);
    if (!keep) begin
      @(negedge clk);
      chk("idle_after", {idle, done}, 2'b10);
    end
  endtask

  always @(posedge clk) rst_q <= reset;

  // Invariants on both instances.
  logic [1:0] pl;  logic pdk;
  logic [2:0] plm; logic pdkm;
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(latch) || !$onehot0(latch_m) || (done && !idle) || (done_m && !idle_m)) begin
      errors++;
      $display("FAIL inv_basic: latch %b latch_m %b done/idle %b%b %b%b required onehot0 and done->idle",
               latch, latch_m, done, idle, done_m, idle_m);
    end
    if (!rst_q) begin
      checks++;
      if ((latch !== pl && !(dclk == pdk && ((latch != 0 && !dclk) || (latch == 0 && dclk)))) ||
          (latch_m !== plm && !(dclk_m == pdkm && ((latch_m != 0 && !dclk_m) || (latch_m == 0 && dclk_m))))) begin
        errors++;
        $display("FAIL inv_latch_edge: latch %b->%b dclk %b->%b, latch_m %b->%b dclk_m %b->%b required stable dclk",
                 pl, latch, pdk, dclk, plm, latch_m, pdkm, dclk_m);
      end
    end
    pl = latch; pdk = dclk; plm = latch_m; pdkm = dclk_m;
  end

  typedef struct { int bank; logic [1:0] bus; } vec_t;
  vec_t tbl [12];

  initial begin
    logic [FW-1:0] rf;
    tbl[0]  = '{0, 2'b10}; tbl[1]  = '{1, 2'b00}; tbl[2]  = '{2, 2'b10};
    tbl[3]  = '{0, 2'b01}; tbl[4]  = '{1, 2'b00}; tbl[5]  = '{2, 2'b10};
    tbl[6]  = '{0, 2'b00}; tbl[7]  = '{1, 2'b10}; tbl[8]  = '{2, 2'b10};
    tbl[9]  = '{0, 2'b00}; tbl[10] = '{1, 2'b01}; tbl[11] = '{2, 2'b10};

    reset = 1'b1; go = 1'b0; go_m = 1'b0; frames = '0; frames_m = 24'h0F8421;
    repeat (2) @(negedge clk);
    chk("reset_state", {data, dclk, latch, idle, done}, {9'h0, 1'b1, 2'b00, 1'b1, 1'b0});
    chk("reset_state_m", {data_m, dclk_m, latch_m, idle_m, done_m}, {2'b00, 1'b1, 3'b000, 1'b1, 1'b0});
    reset = 1'b0;
    @(negedge clk);

    // Frame 0 = 0x8000_0001, everything else zero.
    rf = '0; rf[31:0] = 32'h8000_0001;
    xfer(rf, 1'b0, 1'b0, 1'b0);

    // Lane mapping and LSB-first order on the small instance.
    go_m = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (r == 0 && k == 0) go_m = 1'b0;
        chk($sformatf("map_bus_r%0d_k%0d", r, k), data_m, tbl[r].bus);
        chk($sformatf("map_dclk_r%0d_k%0d", r, k), dclk_m, (k >= 4));
        chk($sformatf("map_latch_r%0d_k%0d", r, k), latch_m,
            (k >= 2 && k < 6) ? 3'(1 << tbl[r].bank) : 3'b000);
        chk($sformatf("map_busy_r%0d_k%0d", r, k), idle_m, 1'b0);
      end
    end
    @(negedge clk);
    chk("map_end", {data_m, dclk_m, latch_m, idle_m, done_m}, {2'b00, 1'b1, 3'b000, 1'b1, 1'b1});
    @(negedge clk);

    // Random transfer with a go pulse mid-transfer.
    xfer(rand_frames(), 1'b0, 1'b1, 1'b0);

    // Snapshot: frames change to all-ones one cycle after go.
    xfer(rand_frames(), 1'b0, 1'b0, 1'b1);
    xfer('1, 1'b0, 1'b0, 1'b0);

    // go held high: back-to-back transfers.
    xfer(rand_frames(), 1'b1, 1'b0, 1'b0);
    xfer(rand_frames(), 1'b1, 1'b0, 1'b0);
    xfer(rand_frames(), 1'b0, 1'b0, 1'b0);

    // Reset during bank-1 LATCH of the first bit.
    frames = rand_frames(); go = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) go = 1'b0;
    end
    chk("pre_reset_latch", latch, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid", {data, dclk, latch, idle, done}, {9'h0, 1'b1, 2'b00, 1'b1, 1'b0});
    reset = 1'b0;
    @(negedge clk);
    xfer(rand_frames(), 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
